checkpoint_rf: RTL and testbench
================================

# checkpoint_rf

Shadow (checkpoint) register file that sits directly downstream of the replay `control` block in the fault-tolerant system. During normal execution it buffers the core's write-back traffic and promotes each write into a verified shadow copy once the error detector clears it. When an error is flagged, it discards all unverified writes. While `control` sweeps `replay_addr` across the register space, it rewrites the core register file from the shadow copy.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: register address width; `NUM_REG = 2**ADDR_WIDTH` shadow entries.
- `DATA_WIDTH`, 32: register data width.
- `PEND_DEPTH`, 4: pending-write FIFO depth (power of two, ≥2).

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `wb_we_i`  in  1: core write-back write enable.
- `wb_addr_i`  in  ADDR_WIDTH: write-back address.
- `wb_data_i`  in  DATA_WIDTH: write-back data.
- `verify_i`  in  1: oldest pending write verified error-free; pop and commit it.
- `error_i`  in  1: error detected; flush pending writes and prepare for replay.
- `replay_idle_i`  in  1: from `control` `fetch_block_o`. 1 = no replay; 0 = replay sweep in progress.
- `replay_addr_i`  in  ADDR_WIDTH: from `control` `replay_addr_o`.
- `stall_o`  out  1: pending FIFO full; core must hold write-back.
- `pend_count_o`  out  $clog2(PEND_DEPTH)+1: pending entries.
- `rf_we_o`  out  1: restore write enable into core register file.
- `rf_waddr_o`  out  ADDR_WIDTH: restore address.
- `rf_wdata_o`  out  DATA_WIDTH: restore data.
- `busy_o`  out  1: state ≠ RUN.

## Operation
- **Reset:**
  - Shadow array all zero.
  - FIFO empty; `pend_count_o` is 0 and `stall_o` is 0.
  - State is RUN.
  - `rf_we_o`, `rf_waddr_o`, `rf_wdata_o` are 0; `busy_o` is 0.
- **States:** RUN, WAIT, REPLAY.
- **RUN:**
  - `wb_we_i` pushes {addr, data} when not full. A push while full is dropped; the core is required to honor `stall_o`.
  - `verify_i` pops the oldest entry and writes its data into `shadow[addr]`. If the FIFO is empty, `verify_i` is ignored.
  - Push and pop in the same cycle are both legal, including when full; the count is unchanged.
  - Entries commit strictly in push order. Later writes to the same address overwrite earlier ones.
- **RUN → WAIT on `error_i`:**
  - Same edge: FIFO cleared and count goes to 0.
  - Any `verify_i` or `wb_we_i` in that cycle is discarded; error has priority.
- **WAIT:**
  - `wb_we_i`, `verify_i` and `error_i` are ignored.
  - → REPLAY when `replay_idle_i` = 0.
- **REPLAY:**
  - Each cycle, sample `replay_addr_i` and read `shadow[replay_addr_i]`.
  - Next cycle: `rf_we_o` = 1, `rf_waddr_o` = sampled address, `rf_wdata_o` = shadow data.
  - The shadow array is never written in WAIT or REPLAY.
  - `error_i` during REPLAY is ignored.
  - → RUN when `replay_idle_i` = 1. No restore write is issued for that cycle.
- **`stall_o` / `busy_o`:**
  - `stall_o` = (count == PEND_DEPTH) in RUN, and 1 in WAIT/REPLAY.
  - `busy_o` = (state ≠ RUN).
- **Address wrap:** replay addresses cover 0..NUM_REG-1. Address 0 is restored like any other; no special case.

## Timing
- Write-back to pending: 1 cycle. The entry is visible in `pend_count_o` the cycle after the push.
- Verify to shadow: the shadow entry is updated at the `verify_i` edge and is readable by replay from the next cycle.
- `error_i` at edge N: `busy_o` = 1 and `pend_count_o` = 0 from N+1.
- Replay: address sampled at edge N gives the restore write on cycle N+1, at 1 write/cycle.
- A full sweep of NUM_REG addresses yields NUM_REG consecutive `rf_we_o` pulses, minus any address `control` skips.
- `rf_we_o` deasserts the cycle after the last sampled replay address.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately (asynchronous).
  - Shadow contents are lost (zeroed).
  - State returns to RUN.

## Structure
- Package `ft_pkg`:
  - `cp_state_t` enum {RUN, WAIT, REPLAY}.
  - `wb_entry_t` struct {addr, data}, parameterized via package-level defaults matching `ADDR_WIDTH`/`DATA_WIDTH`.
- Sub-module `pend_fifo`:
  - Synchronous FIFO of `wb_entry_t`, depth PEND_DEPTH.
  - Asynchronous active-low reset.
  - Synchronous `flush_i` with priority over push/pop.
  - Outputs: count, full, empty.
- Top level contains the state machine, the shadow array and the restore output register.

## Test plan
- Reset, then push 3 writes (r1 = 0x11, r2 = 0x22, r1 = 0x33) and verify 3 → shadow r1 = 0x33, r2 = 0x22; `pend_count_o` returns to 0.
- Push 4 writes with no verify → `stall_o` = 1 with count 4. A 5th push with simultaneous verify → count stays 4, and the oldest entry is committed.
- Push r5 = 0xAA without verify, then assert `error_i` with `verify_i` in the same cycle → count 0, `busy_o` = 1, shadow r5 unchanged (0).
- Error followed by a `control` sweep: `replay_idle_i` = 0 for 32 cycles with addr 0..31 → 32 `rf_we_o` pulses, each 1 cycle after its address, with data equal to shadow. `busy_o` falls 1 cycle after `replay_idle_i` rises.
- `wb_we_i` and `verify_i` asserted during WAIT/REPLAY → ignored; shadow and FIFO unchanged.
- Assert `rst_n` low mid-REPLAY → `rf_we_o` = 0 immediately; after release, state is RUN and all shadow reads return 0.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared types for the fault-tolerant checkpoint path: controller states and
// the write-back entry carried through the pending FIFO.
package ft_pkg;

   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      WAIT   = 2'd1,
      REPLAY = 2'd2
   } cp_state_t;

   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/pend_fifo.sv
// Pending write-back FIFO: holds unverified writes in push order until they are
// verified (popped) or discarded by a flush.
module pend_fifo
   import ft_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = wb_entry_t
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  entry_t                   push_data_i,
   input  logic                     pop_i,
   output entry_t                   pop_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count == (PW+1)'(DEPTH));
   assign empty_o = (count == '0);
   assign count_o = count;
   assign pop_data_o = mem[rd_ptr];

   // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem[wr_ptr] <= push_data_i;
   end

endmodule

// File: rtl/checkpoint_rf.sv
// Checkpoint register file: commits verified write-backs into a shadow copy and
// replays that copy into the core register file after an error.
module checkpoint_rf
   import ft_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int PEND_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wb_we_i,
   input  logic [ADDR_WIDTH-1:0]         wb_addr_i,
   input  logic [DATA_WIDTH-1:0]         wb_data_i,
   input  logic                          verify_i,
   input  logic                          error_i,
   input  logic                          replay_idle_i,
   input  logic [ADDR_WIDTH-1:0]         replay_addr_i,
   output logic                          stall_o,
   output logic [$clog2(PEND_DEPTH):0]   pend_count_o,
   output logic                          rf_we_o,
   output logic [ADDR_WIDTH-1:0]         rf_waddr_o,
   output logic [DATA_WIDTH-1:0]         rf_wdata_o,
   output logic                          busy_o
);

   localparam int NUM_REG = 2**ADDR_WIDTH;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   cp_state_t             state;
   cp_state_t             state_nxt;
   logic                  in_run;
   logic                  push;
   logic                  pop;
   logic                  flush;
   logic                  commit;
   logic                  sample;
   logic                  fifo_full;
   logic                  fifo_empty;
   entry_t                push_entry;
   entry_t                head;
   logic [DATA_WIDTH-1:0] shadow [NUM_REG];

   // Error wins over any write-back or verify presented in the same cycle.
   assign in_run = (state == RUN);
   assign flush  = in_run && error_i;
   assign push   = in_run && !error_i && wb_we_i;
   assign pop    = in_run && !error_i && verify_i;
   assign commit = pop && !fifo_empty;
   assign push_entry = '{addr: wb_addr_i, data: wb_data_i};

   // The cycle that leaves WAIT is already the first sweep cycle of control.
   assign sample = !in_run && !replay_idle_i;

   assign stall_o = in_run ? fifo_full : 1'b1;
   assign busy_o  = !in_run;

   pend_fifo #(
      .DEPTH   (PEND_DEPTH),
      .entry_t (entry_t)
   ) u_pend_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .pop_data_o  (head),
      .count_o     (pend_count_o),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (error_i)        state_nxt = WAIT;
         WAIT:    if (!replay_idle_i) state_nxt = REPLAY;
         REPLAY:  if (replay_idle_i)  state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REG; i++) shadow[i] <= '0;
      end else if (commit) begin
         shadow[head.addr] <= head.data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_o    <= 1'b0;
         rf_waddr_o <= '0;
         rf_wdata_o <= '0;
      end else begin
         rf_we_o <= sample;
         if (sample) begin
            rf_waddr_o <= replay_addr_i;
            rf_wdata_o <= shadow[replay_addr_i];
         end
      end
   end

endmodule

// File: tb/tb_checkpoint_rf.sv
// Directed bench for checkpoint_rf: a queue/array reference model is compared
// against the DUT every cycle, with literal expectations for key scenarios.
module tb_checkpoint_rf;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int D  = 4;
   localparam int NR = 32;
   localparam int M_RUN    = 0;
   localparam int M_WAIT   = 1;
   localparam int M_REPLAY = 2;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   wb_we_i = 1'b0;
   logic [AW-1:0]          wb_addr_i = '0;
   logic [DW-1:0]          wb_data_i = '0;
   logic                   verify_i = 1'b0;
   logic                   error_i = 1'b0;
   logic                   replay_idle_i = 1'b1;
   logic [AW-1:0]          replay_addr_i = '0;
   logic                   stall_o;
   logic [$clog2(D):0]     pend_count_o;
   logic                   rf_we_o;
   logic [AW-1:0]          rf_waddr_o;
   logic [DW-1:0]          rf_wdata_o;
   logic                   busy_o;

   int checks = 0;
   int failures = 0;
   int pulse_cnt = 0;
   logic [DW-1:0] obs [NR];

   always #5 clk = ~clk;

   checkpoint_rf #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .PEND_DEPTH (D)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb_we_i       (wb_we_i),
      .wb_addr_i     (wb_addr_i),
      .wb_data_i     (wb_data_i),
      .verify_i      (verify_i),
      .error_i       (error_i),
      .replay_idle_i (replay_idle_i),
      .replay_addr_i (replay_addr_i),
      .stall_o       (stall_o),
      .pend_count_o  (pend_count_o),
      .rf_we_o       (rf_we_o),
      .rf_waddr_o    (rf_waddr_o),
      .rf_wdata_o    (rf_wdata_o),
      .busy_o        (busy_o)
   );

   // Reference model: pending writes as a queue, shadow as a plain array.
   int                  m_state = M_RUN;
   logic [DW-1:0]       m_shadow [NR];
   logic [AW+DW-1:0]    m_q [$];
   logic [AW+DW-1:0]    m_e;
   logic                m_we = 1'b0;
   logic [AW-1:0]       m_waddr = '0;
   logic [DW-1:0]       m_wdata = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = M_RUN;
         m_q.delete();
         for (int i = 0; i < NR; i++) m_shadow[i] = '0;
         m_we = 1'b0;
         m_waddr = '0;
         m_wdata = '0;
      end else begin
         m_we = (m_state != M_RUN) && !replay_idle_i;
         if (m_we) begin
            m_waddr = replay_addr_i;
            m_wdata = m_shadow[replay_addr_i];
         end
         case (m_state)
            M_RUN: begin
               if (error_i) begin
                  m_q.delete();
                  m_state = M_WAIT;
               end else begin
                  if (verify_i && m_q.size() > 0) begin
                     m_e = m_q.pop_front();
                     m_shadow[m_e[AW+DW-1:DW]] = m_e[DW-1:0];
                  end
                  if (wb_we_i && m_q.size() < D) m_q.push_back({wb_addr_i, wb_data_i});
               end
            end
            M_WAIT:   if (!replay_idle_i) m_state = M_REPLAY;
            M_REPLAY: if (replay_idle_i)  m_state = M_RUN;
            default:  m_state = M_RUN;
         endcase
      end
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, plus restore-pulse capture.
   always @(negedge clk) begin
      check_output("stall", 64'(stall_o), 64'((m_state == M_RUN) ? (m_q.size() == D) : 1));
      check_output("pend_count", 64'(pend_count_o), 64'(m_q.size()));
      check_output("busy", 64'(busy_o), 64'(m_state != M_RUN));
      check_output("rf_we", 64'(rf_we_o), 64'(m_we));
      if (m_we) begin
         check_output("rf_waddr", 64'(rf_waddr_o), 64'(m_waddr));
         check_output("rf_wdata", 64'(rf_wdata_o), 64'(m_wdata));
      end
      if (rf_we_o === 1'b1) begin
         pulse_cnt++;
         obs[rf_waddr_o] = rf_wdata_o;
      end
   end

   task automatic apply_stimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic ver, input logic err, input logic idle,
                                 input logic [AW-1:0] raddr);
      @(negedge clk);
      #1;
      wb_we_i       = we;
      wb_addr_i     = addr;
      wb_data_i     = data;
      verify_i      = ver;
      error_i       = err;
      replay_idle_i = idle;
      replay_addr_i = raddr;
   endtask

   task automatic idle_cycle();
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
   endtask

   task automatic sweep(input logic noisy);
      for (int i = 0; i < NR; i++) begin
         apply_stimulus(noisy & i[0], AW'(3), 32'h77, noisy, noisy & i[1], 1'b0, AW'(i));
      end
      idle_cycle();
   endtask

   initial begin
      #1;
      check_output("reset_pend_count", 64'(pend_count_o), 64'd0);
      check_output("reset_stall", 64'(stall_o), 64'd0);
      check_output("reset_busy", 64'(busy_o), 64'd0);
      check_output("reset_rf_we", 64'(rf_we_o), 64'd0);
      check_output("reset_rf_wdata", 64'(rf_wdata_o), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Three writes, r1 overwritten, then three verifies.
      apply_stimulus(1'b1, AW'(1), 32'h11, 1'b0, 1'b0, 1'b1, '0);
      apply_stimulus(1'b1, AW'(2), 32'h22, 1'b0, 1'b0, 1'b1, '0);
      apply_stimulus(1'b1, AW'(1), 32'h33, 1'b0, 1'b0, 1'b1, '0);
      idle_cycle();
      check_output("three_pushed", 64'(pend_count_o), 64'd3);
      repeat (3) apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, '0);
      idle_cycle();
      check_output("drained", 64'(pend_count_o), 64'd0);

      // Fill to full, then push+verify while full.
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, AW'(8 + i), 32'h80 + i, 1'b0, 1'b0, 1'b1, '0);
      idle_cycle();
      check_output("full_stall", 64'(stall_o), 64'd1);
      check_output("full_count", 64'(pend_count_o), 64'd4);
      apply_stimulus(1'b1, AW'(12), 32'hC0, 1'b1, 1'b0, 1'b1, '0);
      idle_cycle();
      check_output("push_pop_full_count", 64'(pend_count_o), 64'd4);
      repeat (4) apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, '0);
      idle_cycle();
      check_output("drained_again", 64'(pend_count_o), 64'd0);

      // Unverified r5 flushed by an error that coincides with a verify.
      apply_stimulus(1'b1, AW'(5), 32'hAA, 1'b0, 1'b0, 1'b1, '0);
      apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, '0);
      idle_cycle();
      check_output("error_count", 64'(pend_count_o), 64'd0);
      check_output("error_busy", 64'(busy_o), 64'd1);

      // Write-back and verify in WAIT are ignored.
      repeat (2) apply_stimulus(1'b1, AW'(3), 32'h99, 1'b1, 1'b0, 1'b1, '0);
      idle_cycle();
      check_output("wait_count", 64'(pend_count_o), 64'd0);
      check_output("wait_busy", 64'(busy_o), 64'd1);

      // Full sweep with write-back/verify/error noise during REPLAY.
      pulse_cnt = 0;
      for (int i = 0; i < NR; i++) obs[i] = 32'hDEAD_BEEF;
      sweep(1'b1);
      check_output("busy_before_fall", 64'(busy_o), 64'd1);
      idle_cycle();
      check_output("busy_after_fall", 64'(busy_o), 64'd0);
      idle_cycle();
      idle_cycle();
      check_output("sweep_pulses", 64'(pulse_cnt), 64'd32);
      check_output("shadow_r0", 64'(obs[0]), 64'h0);
      check_output("shadow_r1", 64'(obs[1]), 64'h33);
      check_output("shadow_r2", 64'(obs[2]), 64'h22);
      check_output("shadow_r3", 64'(obs[3]), 64'h0);
      check_output("shadow_r5", 64'(obs[5]), 64'h0);
      check_output("shadow_r8", 64'(obs[8]), 64'h80);
      check_output("shadow_r11", 64'(obs[11]), 64'h83);
      check_output("shadow_r12", 64'(obs[12]), 64'hC0);
      check_output("shadow_r31", 64'(obs[31]), 64'h0);
      check_output("post_replay_count", 64'(pend_count_o), 64'd0);

      // Reset asserted in the middle of a replay sweep.
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, '0);
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, AW'(i));
      @(posedge clk);
      #2;
      check_output("mid_replay_we", 64'(rf_we_o), 64'd1);
      rst_n = 1'b0;
      #1;
      check_output("async_reset_we", 64'(rf_we_o), 64'd0);
      check_output("async_reset_busy", 64'(busy_o), 64'd0);
      check_output("async_reset_wdata", 64'(rf_wdata_o), 64'd0);
      idle_cycle();
      rst_n = 1'b1;
      idle_cycle();

      // Fresh sweep: every shadow entry must read back as zero.
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, '0);
      idle_cycle();
      pulse_cnt = 0;
      for (int i = 0; i < NR; i++) obs[i] = 32'hDEAD_BEEF;
      sweep(1'b0);
      repeat (3) idle_cycle();
      check_output("reset_sweep_pulses", 64'(pulse_cnt), 64'd32);
      for (int i = 0; i < NR; i++) check_output("reset_shadow_zero", 64'(obs[i]), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
